bit_serial_adder: RTL and testbench
===================================

// Module: bit_serial_adder
// PURPOSE
//  Parametrised multi-cycle adder: computes s = a + b + ci one bit per clock, LSB first,
//  reusing a single full-adder cell plus a carry flip-flop. Start/busy/done handshake.
//  Sits beside the combinational adders as the low-area option for datapaths that can
//  tolerate WIDTH-cycle latency.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range 2..64
// PORTS
//  clk    in   1      rising-edge clock, sole clock domain
//  rst    in   1      asynchronous, active-high reset
//  start  in   1      request; sampled only in IDLE or DONE
//  a      in   WIDTH  operand A, captured on the accepting edge
//  b      in   WIDTH  operand B, captured on the accepting edge
//  ci     in   1      carry-in, captured on the accepting edge
//  busy   out  1      high while the operation is in progress
//  done   out  1      one-cycle pulse: s/co hold a new result
//  s      out  WIDTH  sum, registered
//  co     out  1      carry-out, registered
// BEHAVIOUR
//  - Reset (async, any time): state=IDLE; busy=0, done=0, s=0, co=0; shift regs, carry
//    and bit counter cleared. An in-flight operation is discarded, with no done pulse.
//  - States: IDLE -> RUN -> DONE -> IDLE.
//    IDLE: start=1 at edge E0 latches a, b into shift regs and carry<=ci; go to RUN.
//    RUN: every edge computes sum=a_sr[0]^b_sr[0]^carry and
//      carry<=(a_sr[0]&b_sr[0])|(carry&(a_sr[0]^b_sr[0])); shifts a_sr/b_sr right;
//      shifts sum into the MSB of the result shift reg; cnt++.
//    After WIDTH RUN edges (edge E0+WIDTH): s<=result, co<=carry; go to DONE.
//    DONE: done=1 for exactly one cycle. start=1 here is accepted like IDLE (back-to-back),
//      giving a new RUN. Otherwise go to IDLE.
//  - busy=1 from edge E0 until edge E0+WIDTH (WIDTH cycles). done rises on the same edge
//    busy falls. busy and done are never both 1.
//  - Latency: result valid WIDTH edges after the accepting edge. Throughput: one op per
//    WIDTH+1 cycles.
//  - start while busy=1 is ignored. a/b/ci changing during RUN has no effect.
//  - s/co keep the previous result through RUN. They change only at completion, then hold
//    until the next completion or reset.
//  - Arithmetic: modulo 2^WIDTH. co is the true carry out of bit WIDTH-1.
//  - Counter width $clog2(WIDTH+1). Terminal count compares to WIDTH exactly, with no
//    wrap-around.
// CONFIGURATION
//  BIT_SERIAL_ADDER_SUB_EN
//  - defined: adds input port `sub` (1 bit), captured with the operands.
//    - sub=1: b is inverted on capture, ci is ignored and carry<=1, so s=a-b mod 2^WIDTH.
//      co=1 means no borrow (a>=b unsigned).
//    - sub=0: the add behaviour above.
//  - undefined: no `sub` port, add only. Timing is identical in both builds.
// TESTING
//  1. WIDTH=4, exhaustive a,b in 0..15, ci in 0..1 -> {co,s}==a+b+ci for all 512 cases.
//  2. WIDTH=8, a=8'hFF b=8'h01 ci=0 -> s=8'h00, co=1. done exactly 8 edges after the
//     accepting edge. busy high 8 cycles.
//  3. Start op (8'h12+8'h34), pulse start with 8'hFF+8'hFF at RUN cycle 3
//     -> second start ignored. Result s=8'h46, co=0. Only one done pulse.
//  4. start held high continuously with new operands in the DONE cycle -> second op
//     accepted there. done pulses every 9 cycles. Results 8'h46 then 8'h0F (8'h0A+8'h05).
//  5. Assert rst at RUN cycle 4 -> busy/done/s/co=0 immediately (async). No done pulse.
//     Next op 8'h80+8'h80 -> s=8'h00, co=1.
//  6. BIT_SERIAL_ADDER_SUB_EN defined:
//     - 8'h05-8'h07 -> s=8'hFE, co=0.
//     - 8'h07-8'h05 -> s=8'h02, co=1.
//     - sub=1 with ci=1 -> same results (ci ignored).

Source files
------------

// File: rtl/bit_serial_adder.sv
// -----------------------------------------------------------------------------
// bit_serial_adder
//   Multi-cycle adder. It computes s = a + b + ci one bit per clock, LSB first,
//   with one full-adder cell and a carry flip-flop. This is the low-area option
//   for datapaths that can accept WIDTH cycles of latency.
//
//   Handshake (valid/ready semantics):
//     - A request is accepted on a rising edge where start=1 and the block is
//       not busy, that is in IDLE or DONE. a, b and ci are captured on that
//       edge.
//     - busy is high for the WIDTH cycles that follow the accepting edge.
//     - done is high for exactly one cycle when s/co hold a new result.
//     - start while busy is ignored. busy and done are never high together.
//
// Parameters
//   WIDTH  operand/result width, 2..64 (default 8)
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request, honoured only in IDLE or DONE
//   sub    (BIT_SERIAL_ADDER_SUB_EN builds only) 1 = compute a - b
//   a, b   operands, captured on the accepting edge
//   ci     carry-in, captured on the accepting edge (ignored when sub=1)
//   busy   operation in progress
//   done   one-cycle pulse, new result on s/co
//   s      registered sum
//   co     registered carry-out (for subtract, 1 = no borrow)
//
// Configuration macro
//   BIT_SERIAL_ADDER_SUB_EN  adds the sub port and the subtract mode. Timing is
//                            the same in both builds.
//
// The FSM state is held in `state`, which a bound checker can probe.
// -----------------------------------------------------------------------------
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef BIT_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             carry;
  logic [CW-1:0]    cnt, cnt_inc;

  logic             accept;
  logic             last;
  logic             sum_bit, carry_next;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic [WIDTH-1:0] res_next;

  // Operand conditioning at capture time. In subtract mode, a - b is formed
  // as a + ~b + 1, so co=1 means no borrow.
`ifdef BIT_SERIAL_ADDER_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : ci;
`else
  assign b_in = b;
  assign c_in = ci;
`endif

  assign accept = start && (state == IDLE || state == DONE_ST);

  // Single full-adder cell working on the current LSBs.
  assign sum_bit    = a_sr[0] ^ b_sr[0] ^ carry;
  assign carry_next = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
  assign res_next   = {sum_bit, res_sr[WIDTH-1:1]};

  // The counter holds the number of RUN edges already taken. The edge that
  // brings it to WIDTH is the final one. There is no wrap-around.
  assign cnt_inc = cnt + CW'(1);
  assign last    = (cnt_inc == CW'(WIDTH));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and output logic.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE_ST;
      end
      DONE_ST: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand shift registers, carry, result assembly and the
  // registered outputs. s/co update only on the final RUN edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      s      <= '0;
      co     <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b_in;
      res_sr <= '0;
      carry  <= c_in;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_next;
      carry  <= carry_next;
      cnt    <= cnt_inc;
      if (last) begin
        s  <= res_next;
        co <= carry_next;
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_adder
//   Bench for bit_serial_adder. It instantiates an 8-bit DUT, which runs the
//   directed and random operations, and a 4-bit DUT, which runs the exhaustive
//   sweep. Drivers push the expected {co,s} into queues. Monitors pop and
//   compare on every done pulse. They also check the latency, the busy length,
//   that busy and done are exclusive, that done is a single-cycle pulse, and
//   that s/co hold between results.
// -----------------------------------------------------------------------------
module tb_bit_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, ci8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       start4 = 1'b0, ci4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy8, done8, co8, busy4, done4, co4;
  logic [7:0] s8;
  logic [3:0] s4;

  int n_vec = 0, n_fail = 0, n_checks = 0;
  int cyc = 0;

  logic [8:0] exp8_q[$];
  int         lat_q[$];
  logic [4:0] exp4_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8),
`ifdef BIT_SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .a(a8), .b(b8), .ci(ci8),
    .busy(busy8), .done(done8), .s(s8), .co(co8)
  );

  bit_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
`ifdef BIT_SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .a(a4), .b(b4), .ci(ci4),
    .busy(busy4), .done(done4), .s(s4), .co(co4)
  );

  // ---------------- reference model ----------------
  function automatic logic [8:0] model8(logic [7:0] a, logic [7:0] b, logic ci, logic sub);
    logic [7:0] d;
    if (sub) begin
      d = a - b;
      return {(a >= b), d};
    end
    return 9'(a) + 9'(b) + 9'(ci);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_not_busy8();
    int guard = 0;
    @(negedge clk);
    while (busy8 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("timeout_busy8", 64'(busy8), 64'd0);
  endtask

  task automatic issue8(logic [7:0] a, logic [7:0] b, logic ci, logic sub);
    wait_not_busy8();
    start8 = 1'b1; a8 = a; b8 = b; ci8 = ci; sub8 = sub;
    exp8_q.push_back(model8(a, b, ci, sub));
    lat_q.push_back(cyc + 1);
    n_vec++;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic issue4(logic [3:0] a, logic [3:0] b, logic ci);
    int guard = 0;
    @(negedge clk);
    while (busy4 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("timeout_busy4", 64'(busy4), 64'd0);
    start4 = 1'b1; a4 = a; b4 = b; ci4 = ci;
    exp4_q.push_back(5'(a) + 5'(b) + 5'(ci));
    n_vec++;
    @(negedge clk);
    start4 = 1'b0;
  endtask

  // ---------------- scoreboard / monitors ----------------
  logic [8:0] last8 = '0;
  int         busy_run = 0;
  logic       prev_done8 = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      last8      = '0;
      busy_run   = 0;
      prev_done8 = 1'b0;
    end else begin
      check("busy_done_excl", 64'(busy8 & done8), 64'd0);
      if (busy8) busy_run++;
      if (done8) begin
        check("done_single_cycle", 64'(prev_done8), 64'd0);
        if (exp8_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_done8: done with no pending op, s=0x%0h co=%0b, expected no pulse", s8, co8);
        end else begin
          check("result8", 64'({co8, s8}), 64'(exp8_q.pop_front()));
          if (lat_q.size() != 0) check("latency8", 64'(cyc - lat_q.pop_front()), 64'd8);
          check("busy_len8", 64'(busy_run), 64'd8);
        end
        busy_run = 0;
        last8    = {co8, s8};
      end else begin
        check("hold8", 64'({co8, s8}), 64'(last8));
      end
      prev_done8 = done8;
    end
  end

  always @(negedge clk) begin
    if (!rst && done4) begin
      if (exp4_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_done4: done with no pending op, s=0x%0h co=%0b, expected no pulse", s4, co4);
      end else begin
        check("result4", 64'({co4, s4}), 64'(exp4_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    logic sub_r;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state8", 64'({busy8, done8, co8, s8}), 64'd0);
    check("reset_state4", 64'({busy4, done4, co4, s4}), 64'd0);
    rst = 1'b0;

    // Wrap-around: 0xFF + 0x01 gives s=0x00 with co=1.
    issue8(8'hFF, 8'h01, 1'b0, 1'b0);

    // A start during RUN is ignored, so only one done pulse appears.
    issue8(8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;

    // Back-to-back: start is held high and the second op is accepted in DONE.
    wait_not_busy8();
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0; sub8 = 1'b0;
    exp8_q.push_back(9'h046);
    lat_q.push_back(cyc + 1);
    n_vec++;
    guard = 0;
    @(negedge clk);
    while (!done8 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("timeout_done_b2b", 64'(done8), 64'd1);
    a8 = 8'h0A; b8 = 8'h05;
    exp8_q.push_back(9'h00F);
    lat_q.push_back(cyc + 1);
    n_vec++;
    @(negedge clk);
    start8 = 1'b0;

    // Asynchronous reset mid-RUN discards the op, and no done pulse follows.
    issue8(8'h55, 8'h11, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", 64'({busy8, done8, co8, s8}), 64'd0);
    exp8_q.delete();
    lat_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    issue8(8'h80, 8'h80, 1'b0, 1'b0);

`ifdef BIT_SERIAL_ADDER_SUB_EN
    issue8(8'h05, 8'h07, 1'b0, 1'b1);
    issue8(8'h07, 8'h05, 1'b0, 1'b1);
    issue8(8'h05, 8'h07, 1'b1, 1'b1);
    issue8(8'h07, 8'h05, 1'b1, 1'b1);
    issue8(8'h07, 8'h07, 1'b1, 1'b1);
`endif

    // Random operations
    for (int i = 0; i < 40; i++) begin
      sub_r = 1'b0;
`ifdef BIT_SERIAL_ADDER_SUB_EN
      sub_r = 1'($urandom_range(0, 1));
`endif
      issue8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), sub_r);
    end

    // Exhaustive sweep on the 4-bit instance
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          issue4(4'(a), 4'(b), 1'(c));

    // Drain
    guard = 0;
    while ((exp8_q.size() != 0 || exp4_q.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", 64'(exp8_q.size() + exp4_q.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
